// File: rtl/aes_sched.sv
// aes_sched: ld/done stimulus scheduler and signature compactor for the AES core.
// Define AES_SCHED_MISR_EN to fold ciphertexts into a MISR instead of keeping the last one.
module aes_sched #(
  parameter int unsigned  NUM_VEC   = 16,
  parameter int unsigned  TIMEOUT   = 63,
  parameter logic [127:0] KEY_SEED  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
  parameter logic [127:0] TEXT_SEED = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         done,
  input  logic [127:0] text_out,
  output logic         ld,
  output logic [127:0] key,
  output logic [127:0] text_in,
  output logic         busy,
  output logic         finish,
  output logic         timeout_err,
  output logic [15:0]  vec_count,
  output logic [127:0] signature
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [15:0] NV = 16'(NUM_VEC);
  localparam logic [7:0]  TO = 8'(TIMEOUT);

  function automatic logic [127:0] lfsr_step(
    input logic [127:0] x
  );
    return {x[126:0], x[127] ^ x[125] ^ x[100] ^ x[98]};
  endfunction

  logic [2:0]   state_q, state_d;
  logic [7:0]   wcnt_q, wcnt_d;
  logic         ld_q, ld_d;
  logic         busy_q, busy_d;
  logic         fin_q, fin_d;
  logic         terr_q, terr_d;
  logic [127:0] key_q, key_d;
  logic [127:0] txt_q, txt_d;
  logic [15:0]  vcnt_q, vcnt_d;
  logic [127:0] sig_q, sig_d;
  logic [15:0]  vcnt_inc;

  assign vcnt_inc = vcnt_q + 16'd1;

  // Next-state and datapath; status flags decode the next state so they stay registered.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    terr_d  = terr_q;
    key_d   = key_q;
    txt_d   = txt_q;
    vcnt_d  = vcnt_q;
    sig_d   = sig_q;
    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          key_d   = KEY_SEED;
          txt_d   = TEXT_SEED;
          sig_d   = '0;
          vcnt_d  = '0;
          terr_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
`ifdef AES_SCHED_MISR_EN
          sig_d = lfsr_step(sig_q) ^ text_out;
`else
          sig_d = text_out;
`endif
          vcnt_d  = vcnt_inc;
          state_d = (vcnt_inc == NV) ? S_FIN : S_NEXT;
        end else if (wcnt_q + 8'd1 == TO) begin
          terr_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_NEXT: begin
        key_d   = lfsr_step(key_q);
        txt_d   = lfsr_step(txt_q);
        state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
    ld_d   = (state_d == S_LOAD);
    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT) ||
             (state_d == S_NEXT);
    fin_d  = (state_d == S_FIN);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      terr_q  <= 1'b0;
      key_q   <= KEY_SEED;
      txt_q   <= TEXT_SEED;
      vcnt_q  <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      terr_q  <= terr_d;
      key_q   <= key_d;
      txt_q   <= txt_d;
      vcnt_q  <= vcnt_d;
      sig_q   <= sig_d;
    end
  end

  assign ld          = ld_q;
  assign key         = key_q;
  assign text_in     = txt_q;
  assign busy        = busy_q;
  assign finish      = fin_q;
  assign timeout_err = terr_q;
  assign vec_count   = vcnt_q;
  assign signature   = sig_q;

endmodule

// File: tb/tb_aes_sched.sv
// tb_aes_sched: directed checks of aes_sched.
// Instance a runs against a fixed-latency core model; instance b is driven by hand.
module tb_aes_sched;

  localparam logic [127:0] KS = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] TS = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] X1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] X2 = 128'h8000_0000_0000_0001_0F0F_F0F0_1234_5678;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start_a = 1'b0;
  logic         done_a;
  logic [127:0] tout_a;
  logic         ld_a, busy_a, fin_a, terr_a;
  logic [127:0] key_a, tin_a, sig_a;
  logic [15:0]  vc_a;

  logic         start_b = 1'b0;
  logic         done_b  = 1'b0;
  logic [127:0] tout_b  = '0;
  logic         ld_b, busy_b, fin_b, terr_b;
  logic [127:0] key_b, tin_b, sig_b;
  logic [15:0]  vc_b;

  aes_sched #(.NUM_VEC(3), .TIMEOUT(63)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .done(done_a),
    .text_out(tout_a), .ld(ld_a), .key(key_a), .text_in(tin_a),
    .busy(busy_a), .finish(fin_a), .timeout_err(terr_a),
    .vec_count(vc_a), .signature(sig_a)
  );

  aes_sched #(.NUM_VEC(2), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .done(done_b),
    .text_out(tout_b), .ld(ld_b), .key(key_b), .text_in(tin_b),
    .busy(busy_b), .finish(fin_b), .timeout_err(terr_b),
    .vec_count(vc_b), .signature(sig_b)
  );

  function automatic logic [127:0] s(input logic [127:0] x);
    return {x[126:0], x[127] ^ x[125] ^ x[100] ^ x[98]};
  endfunction

  // core model: done 20 cycles after it samples ld, ciphertext = text ^ key
  logic [4:0] ccnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) ccnt <= '0;
    else if (ld_a) ccnt <= 5'd1;
    else if (ccnt == 5'd21) ccnt <= '0;
    else if (ccnt != 5'd0) ccnt <= ccnt + 5'd1;
  end
  assign done_a = (ccnt == 5'd21);
  assign tout_a = tin_a ^ key_a;

  int cyc = 0;
  bit mon_en = 1'b0;
  int ld_cyc[$];
  logic [127:0] ld_key[$];
  always @(posedge clk) begin
    if (ld_a && mon_en) begin
      ld_cyc.push_back(cyc);
      ld_key.push_back(key_a);
    end
    cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] k, t, sig;
  int nld;

  initial begin
    step();
    step();
    chk("rst_ld", ld_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_fin", fin_a, 1'b0);
    chk("rst_terr", terr_a, 1'b0);
    chk("rst_key", key_a, KS);
    chk("rst_tin", tin_a, TS);
    chk("rst_vc", vc_a, 16'd0);
    chk("rst_sig", sig_a, 128'd0);
    rst = 1'b1;
    step();

    // normal run on a
    mon_en = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a_ld_first", ld_a, 1'b1);
    chk("a_busy", busy_a, 1'b1);
    for (int i = 0; i < 200 && !fin_a; i++) step();
    chk("a_finish", fin_a, 1'b1);
    mon_en = 1'b0;
    chk("a_nld", 32'(ld_cyc.size()), 32'd3);
    if (ld_cyc.size() == 3) begin
      chk("a_gap1", 32'(ld_cyc[1] - ld_cyc[0]), 32'd23);
      chk("a_gap2", 32'(ld_cyc[2] - ld_cyc[1]), 32'd23);
      chk("a_key0", ld_key[0], KS);
      chk("a_key1", ld_key[1], s(KS));
      chk("a_key2", ld_key[2], s(s(KS)));
    end
    chk("a_vc", vc_a, 16'd3);
    chk("a_terr", terr_a, 1'b0);
    chk("a_busy_end", busy_a, 1'b0);
    k = KS;
    t = TS;
    sig = '0;
    for (int i = 0; i < 3; i++) begin
`ifdef AES_SCHED_MISR_EN
      sig = s(sig) ^ (k ^ t);
`else
      sig = k ^ t;
`endif
      k = s(k);
      t = s(t);
    end
    chk("a_sig", sig_a, sig);
    step();
    chk("a_hold", fin_a, 1'b1);

    // done in IDLE is ignored
    tout_b = X1;
    done_b = 1'b1;
    step();
    step();
    done_b = 1'b0;
    chk("b_idle_busy", busy_b, 1'b0);
    chk("b_idle_vc", vc_b, 16'd0);
    chk("b_idle_sig", sig_b, 128'd0);

    // timeout
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_ld", ld_b, 1'b1);
    for (int i = 0; i < 8; i++) step();
    chk("b_wait8_fin", fin_b, 1'b0);
    chk("b_wait8_busy", busy_b, 1'b1);
    step();
    chk("b_to_fin", fin_b, 1'b1);
    chk("b_to_terr", terr_b, 1'b1);
    chk("b_to_vc", vc_b, 16'd0);

    // restart clears error; done on the last allowed WAIT cycle
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_re_terr", terr_b, 1'b0);
    chk("b_re_ld", ld_b, 1'b1);
    for (int i = 0; i < 8; i++) step();
    tout_b = X1;
    done_b = 1'b1;
    step();
    done_b = 1'b0;
    chk("b_edge_terr", terr_b, 1'b0);
    chk("b_edge_vc", vc_b, 16'd1);
    chk("b_edge_busy", busy_b, 1'b1);
    chk("b_edge_sig", sig_b, X1);
    step();
    chk("b_ld2", ld_b, 1'b1);
    chk("b_key2", key_b, s(KS));
    chk("b_tin2", tin_b, s(TS));
    step();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_start_wait_ld", ld_b, 1'b0);
    chk("b_start_wait_vc", vc_b, 16'd1);
    chk("b_start_wait_busy", busy_b, 1'b1);
    tout_b = X2;
    done_b = 1'b1;
    step();
    done_b = 1'b0;
    chk("b_fin", fin_b, 1'b1);
    chk("b_vc", vc_b, 16'd2);
`ifdef AES_SCHED_MISR_EN
    chk("b_sig", sig_b, s(X1) ^ X2);
`else
    chk("b_sig", sig_b, X2);
`endif

    // reset during the WAIT of vector 2 on a
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    nld = ld_a ? 1 : 0;
    for (int i = 0; i < 100 && nld < 2; i++) begin
      step();
      if (ld_a) nld++;
    end
    chk("m_second_ld", 32'(nld), 32'd2);
    step();
    step();
    step();
    chk("m_pre_busy", busy_a, 1'b1);
    rst = 1'b0;
    #1;
    chk("m_ld", ld_a, 1'b0);
    chk("m_busy", busy_a, 1'b0);
    chk("m_vc", vc_a, 16'd0);
    chk("m_key", key_a, KS);
    step();
    rst = 1'b1;
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("m_re_ld", ld_a, 1'b1);
    chk("m_re_key", key_a, KS);
    chk("m_re_vc", vc_a, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_sched.md
# aes_sched

Self-checking stimulus scheduler for the AES cipher core in the on-chip test flow. It replaces fixed-period cycle counting with a `ld`/`done` handshake. On `start` it seeds key/plaintext, issues one `ld` pulse per vector, waits for the core's `done`, captures `text_out` into a signature, steps its LFSRs, and repeats for `NUM_VEC` vectors. It sits between the chip test pins and the AES core and reports `finish`, a 128-bit `signature` and a sticky `timeout_err`.

## Interface
- `NUM_VEC`, 16: vectors per run; legal range 1..65535.
- `TIMEOUT`, 63: maximum WAIT cycles allowed before `done`; legal range 1..255.
- `KEY_SEED`, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210: key for the first vector.
- `TEXT_SEED`, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF: plaintext for the first vector.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: begins a run when sampled high in IDLE or FINISH.
- `done`  in  1: AES core completion strobe.
- `text_out`  in  128: AES core ciphertext; valid when `done`=1.
- `ld`  out  1: one-cycle load strobe to the core.
- `key`  out  128: key to the core.
- `text_in`  out  128: plaintext to the core.
- `busy`  out  1: high in LOAD, WAIT and NEXT.
- `finish`  out  1: high in FINISH.
- `timeout_err`  out  1: sticky until the next accepted `start`.
- `vec_count`  out  16: number of vectors completed in the current run.
- `signature`  out  128: compacted result.

## Operation
- States: IDLE, LOAD, WAIT, NEXT, FINISH.
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - `ld`, `busy`, `finish`, `timeout_err` = 0.
  - `key` = `KEY_SEED`, `text_in` = `TEXT_SEED`.
  - `vec_count` = 0, `signature` = 0.
- Step function s(x) = {x[126:0], x[127]^x[125]^x[100]^x[98]}. This is the x^128+x^126+x^101+x^99+1 Fibonacci LFSR.
- IDLE/FINISH with `start`=1:
  - `key`←`KEY_SEED`, `text_in`←`TEXT_SEED`.
  - `signature`←0, `vec_count`←0, `timeout_err`←0.
  - Go to LOAD.
- LOAD: `ld`=1 for this cycle only; go to WAIT and clear the wait counter.
- WAIT, `done`=1:
  - Update `signature` with `text_out` (see Configuration).
  - `vec_count`←`vec_count`+1.
  - If the new count equals `NUM_VEC`, go to FINISH; otherwise go to NEXT.
- WAIT, `done`=0: increment the wait counter. When it reaches `TIMEOUT`, set `timeout_err`←1 and go to FINISH; the vector is not counted.
- NEXT: `key`←s(`key`), `text_in`←s(`text_in`); go to LOAD.
- FINISH: hold all outputs until `start`.
- `done` is ignored outside WAIT. `start` is ignored in LOAD, WAIT and NEXT.
- `key`/`text_in` are stable from LOAD until the next NEXT.

## Timing
- `start` sampled at edge 0 gives `ld`=1 in cycle 1.
- The core's `done` in WAIT cycle k (k≥1) produces the next `ld` at cycle k+2 after the previous `ld` cycle (one NEXT cycle, then LOAD).
- Steady-state period per vector = core latency + 2 cycles.
- `done` and timeout in the same cycle: `done` wins; no error is raised.
- `done` in the same cycle as the `ld` pulse is ignored because the FSM is still in LOAD.
- Asserting `rst` mid-run immediately forces the reset values and returns to IDLE; `ld` drops asynchronously.
- `finish` rises on the edge after the final `done` or after the timeout.

## Configuration
- `AES_SCHED_MISR_EN` defined: on each captured `done`, `signature`←s(`signature`) ^ `text_out` (a MISR).
- `AES_SCHED_MISR_EN` undefined: `signature`←`text_out`, so it holds the last captured ciphertext. All other behaviour is identical.

## Test plan
- Reset: hold `rst`=0 → all outputs at the reset values above; `key`=`KEY_SEED`.
- Normal run: `NUM_VEC`=3, a core model asserts `done` 20 cycles after `ld`, `start` pulsed.
  - Exactly 3 `ld` pulses, 23 cycles apart.
  - `key` at the pulses = `KEY_SEED`, s(`KEY_SEED`), s(s(`KEY_SEED`)).
  - `finish`=1, `vec_count`=3, `timeout_err`=0.
- Signature: `text_out` returned as `text_in` ^ `key`.
  - MISR build: `signature` matches a reference-model fold.
  - Without `AES_SCHED_MISR_EN`: `signature` = last `text_in` ^ `key`.
- Timeout: `TIMEOUT`=8, core never asserts `done` → FSM in FINISH 9 cycles after `ld`; `timeout_err`=1, `vec_count`=0. A following `start` clears `timeout_err`.
- Boundaries:
  - `done` on exactly the `TIMEOUT`-th WAIT cycle → counted, no error.
  - `done` pulsed during IDLE, or `start` pulsed during WAIT → no state change.
- Reset mid-run: `rst`=0 during the WAIT of vector 2 → `ld`=0, `busy`=0, IDLE. A new `start` restarts from `KEY_SEED` with `vec_count`=0.
